pipelined_skip_adder: RTL
=========================

# pipelined_skip_adder

Parametrised, pipelined carry-skip adder/subtractor. The operand width is split into fixed-size skip blocks, and a group of blocks is evaluated per pipeline stage. Each block's carry-out is taken from the skip mux when every bit propagates, and from the ripple chain otherwise. Valid/ready handshakes on both sides let it sit between streaming producers and consumers in the adder test datapaths. It adds throughput, subtraction and back-pressure, none of which the single-cycle adders have.

## Interface
- N, 32, operand width; N % (BLK*BPS) == 0 required
- BLK, 4, bits per skip block
- BPS, 2, skip blocks evaluated per pipeline stage; STAGES = N/(BLK*BPS)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  adder can accept this cycle
- a  in  N  operand A
- b  in  N  operand B
- cin  in  1  carry-in (borrow-in when sub=1)
- sub  in  1  0: a+b+cin; 1: a+~b+~cin (a-b-cin)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  N  result
- cout  out  1  carry out of MSB (for sub: 1 = no borrow)
- overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB
- skip_cnt  out  16  present only with SKIP_COUNT_EN (see Configuration)

## Operation
- Operand preparation: b_eff = sub ? ~b : b. c0 = sub ? ~cin : cin.
- Per block j:
  - p = a^b_eff over the block's bits.
  - P_j = &p.
  - Ripple full-adders produce the block sum and ripple carry.
  - Block carry-out = P_j ? block carry-in : ripple carry.
- Stage k (0..STAGES-1) computes blocks k*BPS .. k*BPS+BPS-1 from:
  - the carry registered by stage k-1 (c0 for k=0);
  - operand bits carried forward in pipeline registers.
- Each stage register holds:
  - a valid bit;
  - the sum bits produced so far;
  - the remaining prepared operand bits;
  - the inter-stage carry;
  - the carry into the current MSB, needed by the final stage for overflow.
- Global advance: adv = ~out_valid | out_ready.
  - in_ready = adv.
  - When adv=1, every stage loads from its predecessor. Stage 0 loads in_valid and the new operands.
  - When adv=0, all registers hold.
- Bubbles are not collapsed: an in_valid=0 cycle with adv=1 inserts an invalid slot.
- Transfers occur only on in_valid&in_ready and on out_valid&out_ready. Results leave in acceptance order.
- Outputs come directly from the last stage register.
  - When out_valid=0, sum/cout/overflow hold their last values and are don't-care for the consumer.
- Reset (asynchronous, may occur at any time):
  - all valid bits and data registers clear to 0;
  - outputs become out_valid=0, sum=0, cout=0, overflow=0, skip_cnt=0;
  - in-flight transactions are discarded;
  - in_ready=1 from the first cycle after rst deasserts.

## Timing
- Latency: operands accepted at edge E give out_valid=1 after edge E+STAGES-1. This is STAGES cycles from the in_valid cycle; 4 with defaults.
- Throughput: one result per cycle while out_ready=1.
- Stall: out_valid=1 & out_ready=0 drives in_ready=0 combinationally in the same cycle. Output is held stable until taken.
- Simultaneous output take and input accept in one cycle is legal and required for full throughput.
- Critical path per stage: BLK ripple bits + BPS-1 skip muxes + final-block ripple.

## Configuration
- SKIP_COUNT_EN defined:
  - adds port skip_cnt, a 16-bit saturating counter;
  - each transaction carries one extra pipeline bit: all_p = &(a^b_eff);
  - on each out_valid&out_ready with all_p=1, skip_cnt increments, saturating at 0xFFFF;
  - the counter clears on rst.
- SKIP_COUNT_EN undefined: no skip_cnt port, no extra register bit. Datapath behaviour is identical.

## Test plan
- Carry through full width: a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> after 4 cycles sum=0x00000000, cout=1, overflow=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, cout=0, overflow=1.
- Subtract: a=5, b=7, sub=1, cin=0 -> sum=0xFFFFFFFE, cout=0, overflow=0. Same with cin=1 -> sum=0xFFFFFFFD.
- Back-pressure: send 6 back-to-back random transactions, hold out_ready=0 for 3 cycles once out_valid rises -> in_ready=0 during the stall, outputs held, all 6 results correct and in order, no loss or duplication.
- Reset mid-stream: assert rst with 3 transactions in flight -> out_valid=0 and sum=0 immediately. A fresh transaction after release returns only its own result, 4 cycles later.
- With SKIP_COUNT_EN: a=0xAAAAAAAA, b=0x55555555, cin=1, sub=0 -> sum=0x00000000, cout=1, skip_cnt=1. A following a=1, b=1 leaves skip_cnt=1.

Source files
------------

// File: rtl/pipelined_skip_adder.sv
// pipelined_skip_adder: pipelined carry-skip add/sub with valid/ready; `define SKIP_COUNT_EN adds skip_cnt
module pipelined_skip_adder #(
  parameter int N = 32,
  parameter int BLK = 4,
  parameter int BPS = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         overflow
`ifdef SKIP_COUNT_EN
  ,
  output logic [15:0]  skip_cnt
`endif
);
  localparam int W = BLK * BPS;
  localparam int STAGES = N / W;
  logic adv;
  logic [N-1:0] b_eff;
  function automatic logic [W:0] seg_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c0);
    logic [W-1:0] s;
    logic c, rc, pa;
    s = '0;
    c = c0;
    for (int j = 0; j < BPS; j++) begin
      rc = c;
      pa = 1'b1;
      for (int i = 0; i < BLK; i++) begin
        s[j*BLK+i] = x[j*BLK+i] ^ y[j*BLK+i] ^ rc;
        rc = (x[j*BLK+i] & y[j*BLK+i]) | (rc & (x[j*BLK+i] ^ y[j*BLK+i]));
        pa = pa & (x[j*BLK+i] ^ y[j*BLK+i]);
      end
      c = pa ? c : rc;
    end
    return {c, s};
  endfunction
  assign adv = ~out_valid | out_ready;
  assign in_ready = adv;
  assign b_eff = sub ? ~b : b;
  // each stage keeps only the operand bits still to be added, so widths shrink down the pipe
  for (genvar k = 0; k < STAGES; k++) begin : g
    localparam int RI = N - k * W;
    logic [RI-1:0] ai, bi;
    logic [k*W+W-1:0] si, sq;
    logic vi, ci, vq, cq;
    logic [W:0] r;
    if (k == 0) begin : h
      assign ai = a;
      assign bi = b_eff;
      assign vi = in_valid;
      assign ci = sub ? ~cin : cin;
      assign si = r[W-1:0];
    end else begin : h
      assign ai = g[k-1].o.aq;
      assign bi = g[k-1].o.bq;
      assign vi = g[k-1].vq;
      assign ci = g[k-1].cq;
      assign si = {r[W-1:0], g[k-1].sq};
    end
    assign r = seg_add(ai[W-1:0], bi[W-1:0], ci);
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        vq <= 1'b0;
        cq <= 1'b0;
        sq <= '0;
      end else if (adv) begin
        vq <= vi;
        if (vi) begin
          cq <= r[W];
          sq <= si;
        end
      end
    if (k < STAGES - 1) begin : o
      logic [RI-W-1:0] aq, bq;
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          aq <= '0;
          bq <= '0;
        end else if (adv & vi) begin
          aq <= ai[RI-1:W];
          bq <= bi[RI-1:W];
        end
    end
    if (k == STAGES - 1) begin : l
      logic oq;
      // carry into the MSB is recovered from the MSB sum bit and its operands
      always_ff @(posedge clk or posedge rst)
        if (rst) oq <= 1'b0;
        else if (adv & vi) oq <= r[W] ^ r[W-1] ^ ai[W-1] ^ bi[W-1];
    end
`ifdef SKIP_COUNT_EN
    logic pi, pq;
    if (k == 0) begin : p
      assign pi = &(a ^ b_eff);
    end else begin : p
      assign pi = g[k-1].pq;
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) pq <= 1'b0;
      else if (adv & vi) pq <= pi;
`endif
  end
  assign out_valid = g[STAGES-1].vq;
  assign sum = g[STAGES-1].sq;
  assign cout = g[STAGES-1].cq;
  assign overflow = g[STAGES-1].l.oq;
`ifdef SKIP_COUNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) skip_cnt <= '0;
    else if (out_valid & out_ready & g[STAGES-1].pq & ~&skip_cnt) skip_cnt <= skip_cnt + 16'd1;
`endif
endmodule
